// File: rtl/snake_pkg.sv
// Shared types for PS/2-driven snake control: directions, scan codes, prefix states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_pkg;

   typedef logic [1:0] dir_t;
   typedef logic [7:0] scan_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   // Set-2 make codes; W/A/S/D and arrow keys both steer
   localparam scan_t SC_W     = 8'h1D;
   localparam scan_t SC_A     = 8'h1C;
   localparam scan_t SC_S     = 8'h1B;
   localparam scan_t SC_D     = 8'h23;
   localparam scan_t SC_UP    = 8'h75;
   localparam scan_t SC_DN    = 8'h72;
   localparam scan_t SC_LF    = 8'h6B;
   localparam scan_t SC_RT    = 8'h74;
   localparam scan_t SC_ESC   = 8'h76;
   localparam scan_t SC_SPACE = 8'h29;
   localparam scan_t SC_BREAK = 8'hF0;
   localparam scan_t SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } prefix_state_t;

   typedef struct packed {
      logic dir_vld;
      dir_t dir;
      logic pause;
      logic restart;
   } cmd_t;

   function automatic dir_t dir_reverse(input dir_t d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Bundle between PS/2 receiver + game logic (master) and the direction decoder (slave).
// Latency: n/a (wiring only).
// Backpressure: none; all signals are strobes or levels.
interface ps2_dir_decoder_if;
   import snake_pkg::*;

   logic  key_pressed;
   scan_t scan_code;
   logic  step_tick;
   logic  game_clear;
   dir_t  dir;
   logic  pause_toggle;
   logic  restart;
   logic  code_seen;

   modport master (
      output key_pressed, scan_code, step_tick, game_clear,
      input  dir, pause_toggle, restart, code_seen
   );

   modport slave (
      input  key_pressed, scan_code, step_tick, game_clear,
      output dir, pause_toggle, restart, code_seen
   );

endinterface

// File: rtl/sync_pulse.sv
// N-flop synchroniser with rising-edge detect; rise is combinational, pulse is its registered copy.
// Latency: pulse asserts STAGES+1 clocks after async_in is first sampled high.
// Backpressure: none; input must stay low for STAGES+1 clocks between strobes.
module sync_pulse #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic pulse
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         last_q <= sync_q[STAGES-1];
         pulse  <= rise;
      end
   end

   assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// Turns PS/2 make/break/extended sequences into snake commands with a 2-entry turn queue.
// Latency: commands and queue updates land 1 clock after code_stb (SYNC_STAGES+2 after key_pressed).
// Backpressure: none; turns beyond queue depth, duplicates and reversals are dropped.
module ps2_dir_decoder
   import snake_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter dir_t INIT_DIR    = DIR_RIGHT
) (
   input logic               clk,
   input logic               rst_n,
   ps2_dir_decoder_if.slave  bus
);

   logic          code_rise;
   logic          code_stb;
   scan_t         code_q;
   prefix_state_t state_q;
   prefix_state_t state_d;
   cmd_t          cmd;

   dir_t          dir_q;
   dir_t          q_mem [2];
   logic          q_head;
   logic [1:0]    q_cnt;
   logic          q_tail_idx;
   logic          q_wr_idx;
   dir_t          ref_dir;
   logic          do_pop;
   logic          do_push;

   logic          pause_q;
   logic          restart_q;
   logic          seen_q;

   sync_pulse #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.key_pressed),
      .rise     (code_rise),
      .pulse    (code_stb)
   );

   // Capture on the rise so code_q is already valid during code_stb
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         code_q <= '0;
      else if (code_rise) code_q <= bus.scan_code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.game_clear) begin
         state_d = ST_IDLE;
      end else if (code_stb) begin
         unique case (state_q)
            ST_IDLE: begin
               if (code_q == SC_BREAK)    state_d = ST_BREAK;
               else if (code_q == SC_EXT) state_d = ST_EXT;
            end
            ST_EXT: begin
               if (code_q == SC_BREAK) state_d = ST_EXT_BREAK;
               else                    state_d = ST_IDLE;
            end
            ST_BREAK,
            ST_EXT_BREAK: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cmd = '0;
      if (code_stb) begin
         if (state_q == ST_IDLE) begin
            unique case (code_q)
               SC_W:     begin cmd.dir_vld = 1'b1; cmd.dir = DIR_UP;    end
               SC_S:     begin cmd.dir_vld = 1'b1; cmd.dir = DIR_DOWN;  end
               SC_A:     begin cmd.dir_vld = 1'b1; cmd.dir = DIR_LEFT;  end
               SC_D:     begin cmd.dir_vld = 1'b1; cmd.dir = DIR_RIGHT; end
               SC_ESC:   cmd.pause   = 1'b1;
               SC_SPACE: cmd.restart = 1'b1;
               default:  cmd = '0;
            endcase
         end else if (state_q == ST_EXT) begin
            unique case (code_q)
               SC_UP:   begin cmd.dir_vld = 1'b1; cmd.dir = DIR_UP;    end
               SC_DN:   begin cmd.dir_vld = 1'b1; cmd.dir = DIR_DOWN;  end
               SC_LF:   begin cmd.dir_vld = 1'b1; cmd.dir = DIR_LEFT;  end
               SC_RT:   begin cmd.dir_vld = 1'b1; cmd.dir = DIR_RIGHT; end
               default: cmd = '0;
            endcase
         end
      end
   end

   // Ring of two: tail sits one past head only when full; writes go to head+count
   assign q_tail_idx = q_head ^ q_cnt[1];
   assign q_wr_idx   = q_head ^ q_cnt[0];
   assign ref_dir    = (q_cnt != 2'd0) ? q_mem[q_tail_idx] : dir_q;
   assign do_pop     = bus.step_tick && (q_cnt != 2'd0);
   assign do_push    = cmd.dir_vld
                    && (cmd.dir != ref_dir)
                    && (cmd.dir != dir_reverse(ref_dir))
                    && ((q_cnt != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q    <= INIT_DIR;
         q_mem[0] <= DIR_UP;
         q_mem[1] <= DIR_UP;
         q_head   <= 1'b0;
         q_cnt    <= 2'd0;
      end else if (bus.game_clear) begin
         dir_q  <= INIT_DIR;
         q_head <= 1'b0;
         q_cnt  <= 2'd0;
      end else begin
         if (do_pop) begin
            dir_q  <= q_mem[q_head];
            q_head <= ~q_head;
         end
         if (do_push) q_mem[q_wr_idx] <= cmd.dir;
         unique case ({do_push, do_pop})
            2'b10:   q_cnt <= q_cnt + 2'd1;
            2'b01:   q_cnt <= q_cnt - 2'd1;
            default: q_cnt <= q_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_q   <= 1'b0;
         restart_q <= 1'b0;
         seen_q    <= 1'b0;
      end else begin
         pause_q   <= cmd.pause;
         restart_q <= cmd.restart;
         seen_q    <= code_stb;
      end
   end

   assign bus.dir          = dir_q;
   assign bus.pause_toggle = pause_q;
   assign bus.restart      = restart_q;
   assign bus.code_seen    = seen_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Bench for ps2_dir_decoder: scan-code sequences checked cycle by cycle against a queue-based model.
// Latency/backpressure: model applies each key SYNC_STAGES+1 clocks after key_pressed is sampled high.
module tb_ps2_dir_decoder;

   localparam int SYNC_STAGES = 2;
   localparam int INIT_DIR    = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ps2_dir_decoder_if bus ();

   ps2_dir_decoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;
   int n_pause = 0;
   int n_restart = 0;

   // Model state: committed direction, pending turns, prefix flags, in-flight keys
   int m_dir = INIT_DIR;
   int mq[$];
   bit skip_next = 0;
   bit ext = 0;
   bit m_pause = 0, m_restart = 0, m_seen = 0;
   int pend_code[$];
   int pend_due[$];
   int edge_n = 0;
   bit kp_prev = 0;
   int plain_map[int];
   int ext_map[int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input logic [31:0] dut_val, input int model_val, input int exp);
      chk({name, "_dut"}, dut_val, exp);
      chk({name, "_model"}, model_val, exp);
   endtask

   task automatic model_reset();
      m_dir = INIT_DIR;
      mq.delete();
      skip_next = 0;
      ext = 0;
      m_pause = 0; m_restart = 0; m_seen = 0;
      pend_code.delete();
      pend_due.delete();
      kp_prev = 0;
   endtask

   task automatic model_step();
      bit have, rv, pop, push;
      int c, rd, refd;
      have = 0; rv = 0; rd = 0; c = 0;
      edge_n++;
      m_pause = 0; m_restart = 0; m_seen = 0;
      if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
         have = 1;
         c = pend_code.pop_front();
         void'(pend_due.pop_front());
      end
      if (bus.key_pressed && !kp_prev) begin
         pend_code.push_back(int'(bus.scan_code));
         pend_due.push_back(edge_n + SYNC_STAGES + 1);
      end
      kp_prev = bus.key_pressed;
      if (have) begin
         m_seen = 1;
         if (skip_next) skip_next = 0;
         else if (c == 'hF0) begin skip_next = 1; ext = 0; end
         else if (c == 'hE0 && !ext) ext = 1;
         else begin
            if (ext && ext_map.exists(c))        begin rv = 1; rd = ext_map[c]; end
            else if (!ext && plain_map.exists(c)) begin rv = 1; rd = plain_map[c]; end
            if (!ext && c == 'h76) m_pause = 1;
            if (!ext && c == 'h29) m_restart = 1;
            ext = 0;
         end
      end
      if (bus.game_clear) begin
         mq.delete();
         m_dir = INIT_DIR;
         skip_next = 0;
         ext = 0;
      end else begin
         pop  = bus.step_tick && mq.size() > 0;
         refd = (mq.size() > 0) ? mq[$] : m_dir;
         push = rv && rd != refd && rd != (refd ^ 1) && (mq.size() < 2 || pop);
         if (pop)  m_dir = mq.pop_front();
         if (push) mq.push_back(rd);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dir",          bus.dir,          m_dir);
         chk("pause_toggle", bus.pause_toggle, m_pause);
         chk("restart",      bus.restart,      m_restart);
         chk("code_seen",    bus.code_seen,    m_seen);
         chk("queue_count",  dut.q_cnt,        mq.size());
         if (bus.pause_toggle === 1'b1) n_pause++;
         if (bus.restart === 1'b1)      n_restart++;
      end
   end

   task automatic cyc(input bit kp, input logic [7:0] sc, input bit tick, input bit clr);
      @(negedge clk);
      bus.key_pressed = kp;
      bus.scan_code   = sc;
      bus.step_tick   = tick;
      bus.game_clear  = clr;
      @(posedge clk);
      model_step();
   endtask

   // Key decode lands on cycle 3 of the 7-cycle send window
   task automatic send(input logic [7:0] code, input bit tick_on_decode);
      for (int i = 0; i < 7; i++) cyc(i < 3, code, tick_on_decode && i == 3, 1'b0);
   endtask

   task automatic tick();
      cyc(1'b0, bus.scan_code, 1'b1, 1'b0);
      cyc(1'b0, bus.scan_code, 1'b0, 1'b0);
      #1;
   endtask

   task automatic clear();
      cyc(1'b0, bus.scan_code, 1'b0, 1'b1);
      cyc(1'b0, bus.scan_code, 1'b0, 1'b0);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      plain_map['h1D] = 0; plain_map['h1B] = 1; plain_map['h1C] = 2; plain_map['h23] = 3;
      ext_map['h75] = 0;   ext_map['h72] = 1;   ext_map['h6B] = 2;   ext_map['h74] = 3;

      rst_n = 1'b1;
      bus.key_pressed = 1'b0;
      bus.scan_code   = 8'h00;
      bus.step_tick   = 1'b0;
      bus.game_clear  = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      chk_en = 1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      lit("reset_dir", bus.dir, m_dir, 3);
      lit("reset_cnt", dut.q_cnt, mq.size(), 0);

      // Make UP, then a break of UP that must not queue again
      send(8'h1D, 0); send(8'hF0, 0); send(8'h1D, 0);
      #1 lit("s1_cnt", dut.q_cnt, mq.size(), 1);
      tick();
      lit("s1_dir", bus.dir, m_dir, 0);
      lit("s1_cnt_after", dut.q_cnt, mq.size(), 0);

      // LEFT is a reversal of RIGHT, UP is accepted
      clear();
      send(8'h1C, 0); send(8'h1D, 0);
      #1 lit("s2_cnt", dut.q_cnt, mq.size(), 1);
      tick();
      lit("s2_dir", bus.dir, m_dir, 0);

      // Two extended turns fill the queue; DOWN dropped as overflow
      clear();
      send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'h6B, 0); send(8'h1B, 0);
      #1 lit("s3_cnt", dut.q_cnt, mq.size(), 2);
      tick();
      lit("s3_dir1", bus.dir, m_dir, 0);
      tick();
      lit("s3_dir2", bus.dir, m_dir, 2);
      lit("s3_cnt_after", dut.q_cnt, mq.size(), 0);

      // Full queue with a tick on the same cycle as the DOWN decode
      clear();
      send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'h6B, 0); send(8'h1B, 1);
      #1 lit("s4_dir", bus.dir, m_dir, 0);
      lit("s4_cnt", dut.q_cnt, mq.size(), 2);
      tick();
      lit("s4_dir2", bus.dir, m_dir, 2);
      tick();
      lit("s4_dir3", bus.dir, m_dir, 1);

      // Esc, Space, and an extended RIGHT break
      clear();
      n_pause = 0;
      n_restart = 0;
      send(8'h76, 0); send(8'h29, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
      #1 chk("s5_pause_pulses", n_pause, 1);
      chk("s5_restart_pulses", n_restart, 1);
      lit("s5_dir", bus.dir, m_dir, 3);
      lit("s5_cnt", dut.q_cnt, mq.size(), 0);

      // Reset while a break prefix is pending
      send(8'hF0, 0);
      do_reset();
      send(8'h23, 0); send(8'h23, 0);
      #1 lit("s6_dup_cnt", dut.q_cnt, mq.size(), 0);
      send(8'hF0, 0);
      do_reset();
      send(8'h1D, 0);
      #1 lit("s6_fresh_cnt", dut.q_cnt, mq.size(), 1);
      tick();
      lit("s6_dir", bus.dir, m_dir, 0);
      send(8'h1C, 0); send(8'h1D, 0);
      #1 lit("s6_full_cnt", dut.q_cnt, mq.size(), 2);
      clear();
      lit("s6_clear_dir", bus.dir, m_dir, 3);
      lit("s6_clear_cnt", dut.q_cnt, mq.size(), 0);

      repeat (3) @(posedge clk);
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
